// File: rtl/ghost_pkg.sv
// Shared constants for the ghost movement scheduler: field widths, direction codes,
// LFSR seed/taps and the scheduler state type.
package ghost_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 expressed as a mask over state bits [7:0]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_UPDATE = 2'd2
  } sched_state_t;

  function automatic logic [1:0] dir_reverse(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction

endpackage

// File: rtl/ghost_lfsr.sv
// Free-running 8-bit Fibonacci LFSR that supplies random direction re-picks.
module ghost_lfsr
  import ghost_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lfsr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= LFSR_SEED;
    else      lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  end

endmodule

// File: rtl/ghost_move_sched.sv
// Time-multiplexed ghost movement controller sharing one wall-collision checker.
// Optional GHOST_SCHED_NO_REVERSE_EN: re-picks avoid reversing the ghost's entry direction.
module ghost_move_sched
  import ghost_pkg::*;
#(
  parameter int N_GHOST   = 4,
  parameter int MAX_RETRY = 3,
  parameter int X0        = 200,
  parameter int Y0        = 146
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step,
  output logic                   chk_req,
  output logic [X_W-1:0]         chk_x,
  output logic [Y_W-1:0]         chk_y,
  output logic [1:0]             chk_dir,
  input  logic                   chk_ack,
  input  logic                   chk_free,
  output logic [N_GHOST*X_W-1:0] ghost_x,
  output logic [N_GHOST*Y_W-1:0] ghost_y,
  output logic [N_GHOST*2-1:0]   ghost_dir,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam int IW = (N_GHOST > 1) ? $clog2(N_GHOST) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_GHOST - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  sched_state_t  state, state_d;
  logic [IW-1:0] idx, nxt_idx;
  logic [RW-1:0] rcnt;
  logic          free_q;
  logic          start, retry, adv, move_en, turn_en;

  logic [X_W-1:0] gx [N_GHOST];
  logic [Y_W-1:0] gy [N_GHOST];
  logic [1:0]     gd [N_GHOST];

  logic [X_W-1:0] cur_x, mv_x;
  logic [Y_W-1:0] cur_y, mv_y;
  logic [1:0]     cur_d, skip_pick, new_pick;
  logic [7:0]     lfsr;
  logic [1:0]     lfsr_c;
  logic [5:0]     lfsr_unused;

  function automatic logic [1:0] skip_blocked(input logic [1:0] c, input logic [1:0] blk);
    return (c == blk) ? c + 2'd1 : c;
  endfunction

  ghost_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  assign {lfsr_unused, lfsr_c} = lfsr;

  assign cur_x     = gx[idx];
  assign cur_y     = gy[idx];
  assign cur_d     = gd[idx];
  assign nxt_idx   = idx + 1'b1;
  assign skip_pick = skip_blocked(lfsr_c, cur_d);

`ifdef GHOST_SCHED_NO_REVERSE_EN
  logic [1:0] entry_dir;

  // Direction each ghost had when its turn began; re-picks must not reverse it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       entry_dir <= DIR_UP;
    else if (start) entry_dir <= gd[0];
    else if (adv)   entry_dir <= gd[nxt_idx];
  end

  assign new_pick = (skip_pick == dir_reverse(entry_dir)) ?
                    skip_blocked(skip_pick + 2'd1, cur_d) : skip_pick;
`else
  assign new_pick = skip_pick;
`endif

  always_comb begin
    mv_x = cur_x;
    mv_y = cur_y;
    case (cur_d)
      DIR_UP:    mv_y = cur_y - Y_W'(1);
      DIR_DOWN:  mv_y = cur_y + Y_W'(1);
      DIR_LEFT:  mv_x = cur_x - X_W'(1);
      default:   mv_x = cur_x + X_W'(1);
    endcase
  end

  always_comb begin
    state_d = state;
    start   = 1'b0;
    retry   = 1'b0;
    adv     = 1'b0;
    done    = 1'b0;
    move_en = 1'b0;
    turn_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (step) begin
          start   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (chk_ack) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        move_en = free_q;
        turn_en = !free_q;
        if (!free_q && (rcnt != RETRY_LIM)) begin
          retry   = 1'b1;
          state_d = S_REQ;
        end else if (idx != LAST_IDX) begin
          adv     = 1'b1;
          state_d = S_REQ;
        end else begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      rcnt    <= '0;
      free_q  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_d;
      if (start || adv) begin
        idx  <= start ? '0 : nxt_idx;
        rcnt <= '0;
      end else if (retry) begin
        rcnt <= rcnt + 1'b1;
      end
      if (state == S_REQ && chk_ack) free_q <= chk_free;
      if (step && state != S_IDLE)   overrun <= 1'b1;
    end
  end

  // Only the ghost under service changes, on the edge that ends its UPDATE cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_GHOST; i++) begin
        gx[i] <= X_W'(X0 + 16 * i);
        gy[i] <= Y_W'(Y0);
        gd[i] <= DIR_UP;
      end
    end else if (move_en) begin
      gx[idx] <= mv_x;
      gy[idx] <= mv_y;
    end else if (turn_en) begin
      gd[idx] <= new_pick;
    end
  end

  for (genvar g = 0; g < N_GHOST; g++) begin : g_pack
    assign ghost_x[g*X_W +: X_W] = gx[g];
    assign ghost_y[g*Y_W +: Y_W] = gy[g];
    assign ghost_dir[g*2 +: 2]   = gd[g];
  end

  assign chk_req = (state == S_REQ);
  assign chk_x   = cur_x;
  assign chk_y   = cur_y;
  assign chk_dir = cur_d;
  assign busy    = (state != S_IDLE);

endmodule
